sub_seq_scheduler: RTL and testbench

//  Upstream feeder for the Sequencer. Holds a table of NUM_SLOTS periodic sub-sequence descriptors (netlist addr, net count, period).

---
 rtl/sub_seq_scheduler_pkg.sv | 31 +++
 rtl/sub_seq_scheduler_rr_pick.sv | 37 +++
 rtl/sub_seq_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_sub_seq_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_seq_scheduler_pkg.sv
// Shared types and helpers for the sub-sequence scheduler.
package sub_seq_scheduler_pkg;

   // Run-issue FSM states.
   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait
   } state_e;

   // Width of a descriptor write word {en, period, cnt, addr}.
   function automatic int unsigned cfg_data_wd(input int unsigned nl_addr_wd,
                                               input int unsigned period_wd);
      return 1 + period_wd + 2 * nl_addr_wd;
   endfunction

   // Bit offsets of each descriptor field inside the write word (addr in LSBs).
   function automatic int unsigned cfg_cnt_lsb(input int unsigned nl_addr_wd);
      return nl_addr_wd;
   endfunction

   function automatic int unsigned cfg_period_lsb(input int unsigned nl_addr_wd);
      return 2 * nl_addr_wd;
   endfunction

   function automatic int unsigned cfg_en_bit(input int unsigned nl_addr_wd,
                                              input int unsigned period_wd);
      return 2 * nl_addr_wd + period_wd;
   endfunction

endpackage

// File: rtl/sub_seq_scheduler_rr_pick.sv
// Round-robin first-set finder: lowest set bit at or above ptr, else lowest set bit overall.
module sub_seq_scheduler_rr_pick #(
   parameter int unsigned NUM_SLOTS = 8,
   parameter int unsigned SLOT_WD   = 3
) (
   input  logic [NUM_SLOTS-1:0] pending,
   input  logic [SLOT_WD-1:0]   ptr,
   output logic [SLOT_WD-1:0]   idx,
   output logic                 valid
);

   logic [SLOT_WD-1:0] hi_idx;
   logic [SLOT_WD-1:0] lo_idx;
   logic               hi_valid;
   logic               lo_valid;

   // Two scans: one restricted to slots at/after the pointer, one unrestricted for the wrap.
   always_comb begin
      hi_idx   = '0;
      lo_idx   = '0;
      hi_valid = 1'b0;
      lo_valid = 1'b0;
      for (int j = 0; j < NUM_SLOTS; j++) begin
         if (!hi_valid && pending[j] && (SLOT_WD'(j) >= ptr)) begin
            hi_valid = 1'b1;
            hi_idx   = SLOT_WD'(j);
         end
         if (!lo_valid && pending[j]) begin
            lo_valid = 1'b1;
            lo_idx   = SLOT_WD'(j);
         end
      end
      valid = hi_valid | lo_valid;
      idx   = hi_valid ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/sub_seq_scheduler.sv
// Periodic sub-sequence scheduler: descriptor table, per-slot tick countdowns, and a
// one-at-a-time run-issue FSM feeding the Sequencer.
module sub_seq_scheduler
   import sub_seq_scheduler_pkg::*;
#(
   parameter int unsigned NL_ADDR_WD    = 9,
   parameter int unsigned NUM_SLOTS     = 8,
   parameter int unsigned SLOT_WD       = 3,
   parameter int unsigned PERIOD_WD     = 16,
   parameter int unsigned TIMEOUT_TICKS = 1000
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic                                            enable,
   input  logic                                            sys_tmr_strb,
   input  logic                                            cfg_wr_strb,
   input  logic [SLOT_WD-1:0]                              cfg_wr_idx,
   input  logic [cfg_data_wd(NL_ADDR_WD, PERIOD_WD)-1:0]   cfg_wr_data,
   input  logic                                            host_req_strb,
   input  logic [SLOT_WD-1:0]                              host_req_idx,
   input  logic                                            sub_seq_done,
   output logic                                            sub_seq_strb,
   output logic [NL_ADDR_WD-1:0]                           sub_seq_addr,
   output logic [NL_ADDR_WD-1:0]                           sub_seq_cnt,
   output logic                                            busy,
   output logic [SLOT_WD-1:0]                              active_idx,
   output logic                                            overrun_strb,
   output logic                                            timeout_strb,
   output logic [SLOT_WD-1:0]                              err_idx
);

   localparam int unsigned TMO_WD = $clog2(TIMEOUT_TICKS + 1);

   // Field order matches the write word, so a write is a plain cast.
   typedef struct packed {
      logic                  en;
      logic [PERIOD_WD-1:0]  period;
      logic [NL_ADDR_WD-1:0] cnt;
      logic [NL_ADDR_WD-1:0] addr;
   } slot_t;

   slot_t                 slot_q  [NUM_SLOTS];
   slot_t                 slot_d  [NUM_SLOTS];
   logic [PERIOD_WD-1:0]  cdown_q [NUM_SLOTS];
   logic [PERIOD_WD-1:0]  cdown_d [NUM_SLOTS];
   slot_t                 cfg_slot;

   logic [NUM_SLOTS-1:0]  pend_q, pend_d;
   logic [NUM_SLOTS-1:0]  due_vec, host_vec, wr_vec, clr_vec;
   logic [NUM_SLOTS-1:0]  ovr_tick, ovr_host;

   state_e                state_q, state_d;
   logic [SLOT_WD-1:0]    ptr_q, ptr_d;
   logic [SLOT_WD-1:0]    act_q, act_d;
   logic [SLOT_WD-1:0]    err_q, err_d;
   logic [SLOT_WD-1:0]    pick_idx, ovr_idx;
   logic                  pick_valid, sel_go, tick_en;
   logic                  ovr_d, ovr_q, tmo_strb_d, tmo_strb_q;
   logic [NL_ADDR_WD-1:0] addr_q, addr_d, cnt_q, cnt_d;
   logic [TMO_WD-1:0]     tmo_q, tmo_d;

   assign cfg_slot = slot_t'(cfg_wr_data);
   assign tick_en  = sys_tmr_strb & enable;
   assign clr_vec  = sel_go ? (NUM_SLOTS'(1) << pick_idx) : '0;

   sub_seq_scheduler_rr_pick #(
      .NUM_SLOTS (NUM_SLOTS),
      .SLOT_WD   (SLOT_WD)
   ) u_rr_pick (
      .pending (pend_q),
      .ptr     (ptr_q),
      .idx     (pick_idx),
      .valid   (pick_valid)
   );

   // Per-slot event decode: timer due, accepted host request, config write hit.
   always_comb begin
      due_vec  = '0;
      host_vec = '0;
      wr_vec   = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         due_vec[i]  = tick_en && slot_q[i].en && (slot_q[i].period != '0) &&
                       (cdown_q[i] == PERIOD_WD'(1));
         host_vec[i] = host_req_strb && (host_req_idx == SLOT_WD'(i)) && slot_q[i].en;
         wr_vec[i]   = cfg_wr_strb && (cfg_wr_idx == SLOT_WD'(i));
      end
   end

   // Table, countdown and pending update; a new due/request beats the issue-time clear.
   always_comb begin
      pend_d   = pend_q;
      ovr_tick = '0;
      ovr_host = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_d[i]  = slot_q[i];
         cdown_d[i] = cdown_q[i];
         if (wr_vec[i]) begin
            slot_d[i]  = cfg_slot;
            cdown_d[i] = cfg_slot.period;
            pend_d[i]  = 1'b0;
         end else begin
            if (tick_en && slot_q[i].en && (slot_q[i].period != '0)) begin
               cdown_d[i] = due_vec[i] ? slot_q[i].period : cdown_q[i] - 1'b1;
            end
            ovr_tick[i] = due_vec[i] && pend_q[i] && !clr_vec[i];
            ovr_host[i] = host_vec[i] && pend_q[i] && !clr_vec[i];
            if (due_vec[i] || host_vec[i]) begin
               pend_d[i] = 1'b1;
            end else if (clr_vec[i]) begin
               pend_d[i] = 1'b0;
            end
         end
      end
   end

   // Overrun report: lowest tick-sourced slot first, host request only if no tick overrun.
   always_comb begin
      ovr_d   = 1'b0;
      ovr_idx = host_req_idx;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (ovr_tick[i]) begin
            ovr_d   = 1'b1;
            ovr_idx = SLOT_WD'(i);
         end
      end
      if (!ovr_d && (|ovr_host)) begin
         ovr_d = 1'b1;
      end
   end

   // Error index; a timeout owns it if both strobes fire together.
   always_comb begin
      err_d = err_q;
      if (tmo_strb_d) begin
         err_d = act_q;
      end else if (ovr_d) begin
         err_d = ovr_idx;
      end
   end

   // Issue FSM next state; run descriptor is latched on the IDLE->ISSUE edge.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      act_d      = act_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      tmo_strb_d = 1'b0;
      sel_go     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (enable && pick_valid) begin
               sel_go = 1'b1;
               // Zero-length runs are dropped without touching the Sequencer.
               if (slot_q[pick_idx].cnt != '0) begin
                  state_d = StIssue;
                  act_d   = pick_idx;
                  addr_d  = slot_q[pick_idx].addr;
                  cnt_d   = slot_q[pick_idx].cnt;
                  ptr_d   = (pick_idx == SLOT_WD'(NUM_SLOTS - 1)) ? '0 : pick_idx + 1'b1;
               end
            end
         end
         StIssue: begin
            tmo_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (sub_seq_done) begin
               state_d = StIdle;
            end else if (sys_tmr_strb) begin
               if (tmo_q == TMO_WD'(TIMEOUT_TICKS - 1)) begin
                  tmo_strb_d = 1'b1;
                  state_d    = StIdle;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_q[i]  <= '0;
            cdown_q[i] <= '0;
         end
         pend_q     <= '0;
         state_q    <= StIdle;
         ptr_q      <= '0;
         act_q      <= '0;
         err_q      <= '0;
         addr_q     <= '0;
         cnt_q      <= '0;
         tmo_q      <= '0;
         ovr_q      <= 1'b0;
         tmo_strb_q <= 1'b0;
      end else begin
         slot_q     <= slot_d;
         cdown_q    <= cdown_d;
         pend_q     <= pend_d;
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         act_q      <= act_d;
         err_q      <= err_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         ovr_q      <= ovr_d;
         tmo_strb_q <= tmo_strb_d;
      end
   end

   assign sub_seq_strb = (state_q == StIssue);
   assign busy         = (state_q != StIdle);
   assign sub_seq_addr = addr_q;
   assign sub_seq_cnt  = cnt_q;
   assign active_idx   = act_q;
   assign overrun_strb = ovr_q;
   assign timeout_strb = tmo_strb_q;
   assign err_idx      = err_q;

endmodule

// File: tb/tb_sub_seq_scheduler.sv
// Directed bench for sub_seq_scheduler (TIMEOUT_TICKS reduced to 4).
module tb_sub_seq_scheduler;

   localparam int CFG_WD = 35;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              enable = 1'b0;
   logic              sys_tmr_strb = 1'b0;
   logic              cfg_wr_strb = 1'b0;
   logic [2:0]        cfg_wr_idx = '0;
   logic [CFG_WD-1:0] cfg_wr_data = '0;
   logic              host_req_strb = 1'b0;
   logic [2:0]        host_req_idx = '0;
   logic              sub_seq_done = 1'b0;
   logic              sub_seq_strb;
   logic [8:0]        sub_seq_addr;
   logic [8:0]        sub_seq_cnt;
   logic              busy;
   logic [2:0]        active_idx;
   logic              overrun_strb;
   logic              timeout_strb;
   logic [2:0]        err_idx;

   int total = 0;
   int bad = 0;

   sub_seq_scheduler #(
      .NL_ADDR_WD    (9),
      .NUM_SLOTS     (8),
      .SLOT_WD       (3),
      .PERIOD_WD     (16),
      .TIMEOUT_TICKS (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .sys_tmr_strb  (sys_tmr_strb),
      .cfg_wr_strb   (cfg_wr_strb),
      .cfg_wr_idx    (cfg_wr_idx),
      .cfg_wr_data   (cfg_wr_data),
      .host_req_strb (host_req_strb),
      .host_req_idx  (host_req_idx),
      .sub_seq_done  (sub_seq_done),
      .sub_seq_strb  (sub_seq_strb),
      .sub_seq_addr  (sub_seq_addr),
      .sub_seq_cnt   (sub_seq_cnt),
      .busy          (busy),
      .active_idx    (active_idx),
      .overrun_strb  (overrun_strb),
      .timeout_strb  (timeout_strb),
      .err_idx       (err_idx)
   );

   always #5 clk = ~clk;

   function automatic logic [CFG_WD-1:0] mk(input logic en, input logic [15:0] per,
                                            input logic [8:0] cnt, input logic [8:0] addr);
      return {en, per, cnt, addr};
   endfunction

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      enable = 1'b0; sys_tmr_strb = 1'b0; cfg_wr_strb = 1'b0;
      host_req_strb = 1'b0; sub_seq_done = 1'b0;
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic cfg(input logic [2:0] idx, input logic [CFG_WD-1:0] d);
      cfg_wr_idx = idx; cfg_wr_data = d; cfg_wr_strb = 1'b1;
      cyc();
      cfg_wr_strb = 1'b0;
   endtask

   task automatic tick();
      sys_tmr_strb = 1'b1;
      cyc();
      sys_tmr_strb = 1'b0;
   endtask

   task automatic host(input logic [2:0] idx);
      host_req_idx = idx; host_req_strb = 1'b1;
      cyc();
      host_req_strb = 1'b0;
   endtask

   // From the ISSUE sample: one cycle into WAIT, then a done pulse.
   task automatic finish_run();
      cyc();
      sub_seq_done = 1'b1;
      cyc();
      sub_seq_done = 1'b0;
   endtask

   task automatic wait_strb(input int budget, output bit seen);
      seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         cyc();
         if (sub_seq_strb === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (sub_seq_strb !== 1'b0) begin bad++; $display("FAIL rst_strb got=%b want=0", sub_seq_strb); end
      total++; if (sub_seq_addr !== 9'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", sub_seq_addr); end
      total++; if (sub_seq_cnt !== 9'h0) begin bad++; $display("FAIL rst_cnt got=%h want=0", sub_seq_cnt); end
      total++; if (overrun_strb !== 1'b0) begin bad++; $display("FAIL rst_ovr got=%b want=0", overrun_strb); end
      total++; if (timeout_strb !== 1'b0) begin bad++; $display("FAIL rst_tmo got=%b want=0", timeout_strb); end
      total++; if (err_idx !== 3'd0) begin bad++; $display("FAIL rst_err got=%0d want=0", err_idx); end
   endtask

   task automatic test_periodic();
      do_reset();
      enable = 1'b1;
      cfg(3'd0, mk(1'b1, 16'd3, 9'd5, 9'h010));
      for (int r = 0; r < 2; r++) begin
         tick();
         total++; if (sub_seq_strb !== 1'b0) begin bad++; $display("FAIL per_t1 r=%0d got=%b want=0", r, sub_seq_strb); end
         tick();
         tick();
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL per_t3 r=%0d busy got=%b want=0", r, busy); end
         cyc();
         total++; if (sub_seq_strb !== 1'b1) begin bad++; $display("FAIL per_strb r=%0d got=%b want=1", r, sub_seq_strb); end
         total++; if (sub_seq_addr !== 9'h010) begin bad++; $display("FAIL per_addr r=%0d got=%h want=010", r, sub_seq_addr); end
         total++; if (sub_seq_cnt !== 9'd5) begin bad++; $display("FAIL per_cnt r=%0d got=%0d want=5", r, sub_seq_cnt); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL per_busy r=%0d got=%b want=1", r, busy); end
         cyc();
         total++; if (sub_seq_strb !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL per_wait r=%0d strb=%b busy=%b want 0/1", r, sub_seq_strb, busy); end
         cyc();
         cyc();
         sub_seq_done = 1'b1;
         cyc();
         sub_seq_done = 1'b0;
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL per_done r=%0d busy got=%b want=0", r, busy); end
      end
   endtask

   task automatic test_round_robin();
      bit seen;
      logic [2:0] order [5];
      order = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd0};
      do_reset();
      enable = 1'b1;
      cfg(3'd1, mk(1'b1, 16'd2, 9'd1, 9'h101));
      cfg(3'd2, mk(1'b1, 16'd2, 9'd1, 9'h102));
      cfg(3'd5, mk(1'b1, 16'd2, 9'd1, 9'h105));
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         if (k == 3) begin
            // Queue slots 0 and 6 together; the pointer now sits at 6.
            enable = 1'b0;
            cfg(3'd0, mk(1'b1, 16'd0, 9'd1, 9'h100));
            cfg(3'd6, mk(1'b1, 16'd0, 9'd1, 9'h106));
            host(3'd0);
            host(3'd6);
            enable = 1'b1;
         end
         wait_strb(8, seen);
         total++; if (seen !== 1'b1) begin bad++; $display("FAIL rr_seen k=%0d got=%b want=1", k, seen); end
         total++; if (active_idx !== order[k]) begin bad++; $display("FAIL rr_idx k=%0d got=%0d want=%0d", k, active_idx, order[k]); end
         total++; if (sub_seq_addr !== {6'h20, order[k]}) begin bad++; $display("FAIL rr_addr k=%0d got=%h want=%h", k, sub_seq_addr, {6'h20, order[k]}); end
         finish_run();
      end
   endtask

   task automatic test_overrun();
      bit seen;
      int strbs;
      do_reset();
      enable = 1'b1;
      cfg(3'd3, mk(1'b1, 16'd1, 9'd2, 9'h033));
      tick();
      wait_strb(6, seen);
      total++; if (seen !== 1'b1 || active_idx !== 3'd3) begin bad++; $display("FAIL ovr_issue seen=%b idx=%0d want 1/3", seen, active_idx); end
      tick();
      total++; if (overrun_strb !== 1'b0) begin bad++; $display("FAIL ovr_first got=%b want=0", overrun_strb); end
      tick();
      total++; if (overrun_strb !== 1'b1) begin bad++; $display("FAIL ovr_strb got=%b want=1", overrun_strb); end
      total++; if (err_idx !== 3'd3) begin bad++; $display("FAIL ovr_err got=%0d want=3", err_idx); end
      cyc();
      total++; if (overrun_strb !== 1'b0) begin bad++; $display("FAIL ovr_pulse got=%b want=0", overrun_strb); end
      sub_seq_done = 1'b1;
      cyc();
      sub_seq_done = 1'b0;
      strbs = 0;
      for (int n = 0; n < 8; n++) begin
         cyc();
         if (sub_seq_strb === 1'b1) strbs++;
      end
      total++; if (strbs !== 1) begin bad++; $display("FAIL ovr_queued got=%0d want=1", strbs); end
   endtask

   task automatic test_timeout();
      bit seen;
      do_reset();
      cfg(3'd4, mk(1'b1, 16'd0, 9'd3, 9'h044));
      cfg(3'd6, mk(1'b1, 16'd0, 9'd7, 9'h066));
      host(3'd4);
      host(3'd6);
      enable = 1'b1;
      wait_strb(6, seen);
      total++; if (seen !== 1'b1 || active_idx !== 3'd4) begin bad++; $display("FAIL tmo_issue seen=%b idx=%0d want 1/4", seen, active_idx); end
      cyc();
      for (int t = 1; t <= 3; t++) begin
         tick();
         total++; if (timeout_strb !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_early t=%0d tmo=%b busy=%b want 0/1", t, timeout_strb, busy); end
      end
      tick();
      total++; if (timeout_strb !== 1'b1) begin bad++; $display("FAIL tmo_strb got=%b want=1", timeout_strb); end
      total++; if (err_idx !== 3'd4) begin bad++; $display("FAIL tmo_err got=%0d want=4", err_idx); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_idle busy got=%b want=0", busy); end
      wait_strb(6, seen);
      total++; if (seen !== 1'b1 || active_idx !== 3'd6) begin bad++; $display("FAIL tmo_next seen=%b idx=%0d want 1/6", seen, active_idx); end
      total++; if (sub_seq_cnt !== 9'd7) begin bad++; $display("FAIL tmo_next_cnt got=%0d want=7", sub_seq_cnt); end
      cyc();
      tick();
      tick();
      tick();
      sys_tmr_strb = 1'b1;
      sub_seq_done = 1'b1;
      cyc();
      sys_tmr_strb = 1'b0;
      sub_seq_done = 1'b0;
      total++; if (timeout_strb !== 1'b0) begin bad++; $display("FAIL tmo_done_wins got=%b want=0", timeout_strb); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_done_idle busy got=%b want=0", busy); end
   endtask

   task automatic test_host_edge();
      bit seen;
      do_reset();
      enable = 1'b1;
      cfg(3'd7, mk(1'b1, 16'd0, 9'd0, 9'h077));
      host(3'd7);
      wait_strb(6, seen);
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL host_cnt0 strb got=%b want=0", seen); end
      host(3'd7);
      total++; if (overrun_strb !== 1'b0) begin bad++; $display("FAIL host_cleared ovr got=%b want=0", overrun_strb); end
      host(3'd2);
      wait_strb(6, seen);
      total++; if (seen !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL host_en0 strb=%b busy=%b want 0/0", seen, busy); end
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      do_reset();
      enable = 1'b1;
      cfg(3'd1, mk(1'b1, 16'd0, 9'd9, 9'h1AB));
      host(3'd1);
      wait_strb(6, seen);
      total++; if (seen !== 1'b1 || sub_seq_addr !== 9'h1AB) begin bad++; $display("FAIL mrst_issue seen=%b addr=%h want 1/1ab", seen, sub_seq_addr); end
      cyc();
      reset = 1'b1;
      cyc();
      total++; if (busy !== 1'b0 || sub_seq_addr !== 9'h0 || sub_seq_cnt !== 9'h0 || active_idx !== 3'd0) begin
         bad++; $display("FAIL mrst_outs busy=%b addr=%h cnt=%h idx=%0d want all 0", busy, sub_seq_addr, sub_seq_cnt, active_idx);
      end
      reset = 1'b0;
      sub_seq_done = 1'b1;
      cyc();
      sub_seq_done = 1'b0;
      total++; if (busy !== 1'b0 || sub_seq_strb !== 1'b0) begin bad++; $display("FAIL mrst_late_done busy=%b strb=%b want 0/0", busy, sub_seq_strb); end
      host(3'd1);
      wait_strb(6, seen);
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL mrst_table_en strb got=%b want=0", seen); end
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_round_robin();
      test_overrun();
      test_timeout();
      test_host_edge();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
